display_arbiter: RTL and testbench

Shares the single eight-digit seven-segment display between up to `NUM_REQ` requesters (game FSM, per-player score units, debug), one at a time. Each request carries a card (suit, rank) and two scores. The arbiter chooses a winner round-robin, latches its payload, drives the display controller's `suit`/`rank`/`suit_score`/`rank_score` inputs, and holds them for a fixed dwell time before serving the next requester.

---
 rtl/display_arbiter.sv | 108 ++++++++++
 tb/tb_display_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - round-robin owner of the seven-segment display; DISP_ARB_PREEMPT_EN lets requester 0 preempt
module display_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = 100_000_000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [NUM_REQ-1:0]    req_in,
    input  logic [NUM_REQ*20-1:0] payload_in,
    output logic [NUM_REQ-1:0]    grant_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [1:0]            suit_out,
    output logic [3:0]            rank_out,
    output logic [6:0]            suit_score_out,
    output logic [6:0]            rank_score_out
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    state_t          state;
    logic [IW-1:0]   last;
    logic [CW-1:0]   cnt;

    logic [IW-1:0]   win_idx;
    logic            win_vld;
    logic [19:0]     win_pl;
    logic            preempt;
    logic            load;
    logic [19:0]     sel_pl;
    logic [IW-1:0]   sel_idx;
    int              j;

    function automatic logic [6:0] clamp99(input logic [6:0] v);
        return (v > 7'd99) ? 7'd99 : v;
    endfunction

    // Search starts one past the previous owner so every requester gets a turn
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        j       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(last) + k) % NUM_REQ;
            if (!win_vld && req_in[j]) begin
                win_vld = 1'b1;
                win_idx = IW'(j);
            end
        end
    end

    assign win_pl = payload_in[int'(win_idx)*20 +: 20];

`ifdef DISP_ARB_PREEMPT_EN
    assign preempt = (state == SHOW) && req_in[0] && (last != '0);
`else
    assign preempt = 1'b0;
`endif

    assign load    = ((state == IDLE) && win_vld) || preempt;
    assign sel_pl  = preempt ? payload_in[19:0] : win_pl;
    assign sel_idx = preempt ? '0 : win_idx;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state          <= IDLE;
            last           <= IW'(NUM_REQ - 1);
            cnt            <= '0;
            grant_out      <= '0;
            busy_out       <= 1'b0;
            done_out       <= 1'b0;
            suit_out       <= '0;
            rank_out       <= '0;
            suit_score_out <= '0;
            rank_score_out <= '0;
        end else begin
            grant_out <= '0;
            done_out  <= 1'b0;
            if (load) begin
                suit_out       <= sel_pl[19:18];
                rank_out       <= sel_pl[17:14];
                suit_score_out <= clamp99(sel_pl[13:7]);
                rank_score_out <= clamp99(sel_pl[6:0]);
                grant_out      <= NUM_REQ'(1) << sel_idx;
                last           <= sel_idx;
                cnt            <= '0;
                busy_out       <= 1'b1;
                state          <= SHOW;
            end else if (state == SHOW) begin
                if (cnt == CW'(DWELL_CYCLES - 1)) begin
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end else begin
                    cnt      <= cnt + 1'b1;
                    // done is registered, so raise it one edge before the final count
                    done_out <= (cnt == CW'(DWELL_CYCLES - 2));
                end
            end
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - self-checking bench for display_arbiter (NUM_REQ=4, DWELL_CYCLES=8)
module tb_display_arbiter;

    localparam int N = 4;
    localparam int D = 8;
`ifdef DISP_ARB_PREEMPT_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic           clk_in = 1'b0;
    logic           rst_in = 1'b0;
    logic [N-1:0]   req_in = '0;
    logic [N*20-1:0] payload_in = '0;
    logic [N-1:0]   grant_out;
    logic           busy_out;
    logic           done_out;
    logic [1:0]     suit_out;
    logic [3:0]     rank_out;
    logic [6:0]     suit_score_out;
    logic [6:0]     rank_score_out;

    display_arbiter #(.NUM_REQ(N), .DWELL_CYCLES(D)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .req_in         (req_in),
        .payload_in     (payload_in),
        .grant_out      (grant_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .suit_out       (suit_out),
        .rank_out       (rank_out),
        .suit_score_out (suit_score_out),
        .rank_score_out (rank_score_out)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: remaining display cycles, previous owner, and what the display must show
    int         m_left = 0;
    int         m_last = N - 1;
    logic [3:0] m_grant = '0;
    logic [1:0] m_suit = '0;
    logic [3:0] m_rank = '0;
    logic [6:0] m_ss = '0;
    logic [6:0] m_rs = '0;
    bit         started = 1'b0;
    int         mj;

    int g_idx[$];
    int g_cyc[$];
    int last_done = -1;
    bit seen_g2 = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic grab(input int i);
        logic [19:0] p;
        p       = payload_in[i*20 +: 20];
        m_grant = 4'(1 << i);
        m_last  = i;
        m_suit  = p[19:18];
        m_rank  = p[17:14];
        m_ss    = (p[13:7] > 7'd99) ? 7'd99 : p[13:7];
        m_rs    = (p[6:0]  > 7'd99) ? 7'd99 : p[6:0];
        m_left  = D;
    endtask

    always @(posedge clk_in) begin
        cyc++;
        started = 1'b1;
        m_grant = '0;
        if (!rst_in) begin
            m_left = 0;
            m_last = N - 1;
            m_suit = '0;
            m_rank = '0;
            m_ss   = '0;
            m_rs   = '0;
        end else if (PRE && m_left > 0 && req_in[0] && m_last != 0) begin
            grab(0);
        end else if (m_left > 0) begin
            m_left--;
        end else if (req_in != '0) begin
            for (int k = 1; k <= N; k++) begin
                mj = (m_last + k) % N;
                if (req_in[mj]) begin
                    grab(mj);
                    break;
                end
            end
        end
    end

    always @(negedge clk_in) begin
        if (started) begin
            chk("cycle_outputs",
                {grant_out, busy_out, done_out, suit_out, rank_out, suit_score_out, rank_score_out},
                {m_grant, (m_left > 0), (m_left == 1), m_suit, m_rank, m_ss, m_rs});
            for (int i = 0; i < N; i++) begin
                if (grant_out[i]) begin
                    g_idx.push_back(i);
                    g_cyc.push_back(cyc);
                end
            end
            if (done_out) last_done = cyc;
            if (grant_out[2]) seen_g2 = 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #2;
    endtask

    task automatic set_pl(input int i, input logic [1:0] s, input logic [3:0] r,
                          input logic [6:0] ss, input logic [6:0] rs);
        payload_in[i*20 +: 20] = {s, r, ss, rs};
    endtask

    int  g3c;
    int  g0c;
    int  done_before;
    bit  got;

    initial begin
        // Reset then idle
        step(3);
        rst_in = 1'b1;
        step(5);
        chk("reset_busy", busy_out, 0);
        chk("reset_display", {suit_out, rank_out, suit_score_out, rank_score_out}, 0);
        chk("reset_grant", grant_out, 0);

        // Single request
        set_pl(0, 2'd3, 4'd12, 7'd42, 7'd7);
        req_in = 4'b0001;
        step(1);
        req_in = '0;
        chk("single_grant", grant_out, 4'b0001);
        chk("single_display", {suit_out, rank_out, suit_score_out, rank_score_out},
            {2'd3, 4'd12, 7'd42, 7'd7});
        step(7);
        chk("single_done", {busy_out, done_out}, 2'b11);
        step(1);
        chk("single_idle", {busy_out, done_out}, 2'b00);
        chk("single_hold", {suit_out, rank_out, suit_score_out, rank_score_out},
            {2'd3, 4'd12, 7'd42, 7'd7});

        // Round-robin from a fresh reset
        rst_in = 1'b0;
        step(1);
        rst_in = 1'b1;
        for (int i = 0; i < N; i++) set_pl(i, 2'(i), 4'(i + 1), 7'(10 * i), 7'(10 * i + 5));
        g_idx.delete();
        g_cyc.delete();
        req_in = 4'b1111;
        step(38);
        req_in = '0;
        step(10);
        if (!PRE) begin
            chk("rr_count", g_idx.size(), 5);
            if (g_idx.size() == 5) begin
                chk("rr_order", {g_idx[0], g_idx[1], g_idx[2], g_idx[3], g_idx[4]},
                    {32'd0, 32'd1, 32'd2, 32'd3, 32'd0});
                for (int i = 1; i < 5; i++) chk("rr_spacing", g_cyc[i] - g_cyc[i-1], 9);
            end
        end

        // Score clamp
        set_pl(1, 2'd1, 4'd5, 7'd120, 7'd99);
        req_in = 4'b0010;
        step(1);
        req_in = '0;
        chk("clamp_scores", {suit_score_out, rank_score_out}, {7'd99, 7'd99});
        chk("clamp_card", {suit_out, rank_out}, {2'd1, 4'd5});
        step(9);

        // Withdraw during SHOW
        set_pl(0, 2'd1, 4'd9, 7'd50, 7'd60);
        seen_g2 = 1'b0;
        req_in = 4'b0001;
        step(1);
        req_in = '0;
        step(2);
        req_in = 4'b0100;
        step(3);
        req_in = '0;
        step(8);
        chk("withdraw_no_grant", seen_g2, 0);
        chk("withdraw_display", {suit_out, rank_out, suit_score_out, rank_score_out},
            {2'd1, 4'd9, 7'd50, 7'd60});
        chk("withdraw_idle", busy_out, 0);

        // Requester 0 arrives mid-dwell of requester 3
        set_pl(3, 2'd2, 4'd13, 7'd11, 7'd22);
        set_pl(0, 2'd0, 4'd1, 7'd33, 7'd44);
        req_in = 4'b1000;
        step(1);
        req_in = '0;
        chk("pre_g3", grant_out, 4'b1000);
        g3c = cyc;
        done_before = last_done;
        step(3);
        req_in = 4'b0001;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            step(1);
            if (grant_out[0]) got = 1'b1;
        end
        req_in = '0;
        chk("pre_grant_seen", got, 1);
        g0c = cyc;
        chk("pre_display", {suit_out, rank_out, suit_score_out, rank_score_out},
            {2'd0, 4'd1, 7'd33, 7'd44});
        if (PRE) begin
            chk("pre_latency", g0c - g3c, 4);
            chk("pre_no_done_for_3", last_done, done_before);
            step(9);
            chk("pre_done_cycle", last_done, g0c + 7);
        end else begin
            chk("nopre_done_3", last_done, g3c + 7);
            chk("nopre_grant_gap", g0c - last_done, 2);
            step(9);
        end

        // Reset in the middle of SHOW
        req_in = 4'b0010;
        step(1);
        req_in = '0;
        step(3);
        rst_in = 1'b0;
        step(1);
        chk("midreset_busy", busy_out, 0);
        chk("midreset_display", {suit_out, rank_out, suit_score_out, rank_score_out}, 0);
        rst_in = 1'b1;
        step(3);
        chk("midreset_stays_idle", {grant_out, busy_out}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
